// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Execute-stage RV32I ALU with iterative MUL/DIVU/REMU engine
//             behind a start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int D_WIDTH   = 32,
    parameter int MULDIV_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               alusrc,
    input  logic [3:0]         aluctrl,
    input  logic [D_WIDTH-1:0] aluop1,
    input  logic [D_WIDTH-1:0] immop,
    input  logic [D_WIDTH-1:0] regop2,
    output logic [D_WIDTH-1:0] aluout,
    output logic               busy,
    output logic               done,
    output logic               eq,
    output logic [D_WIDTH-1:0] aluop2
);

    localparam int CW = $clog2(D_WIDTH + 1);
    localparam int SW = $clog2(D_WIDTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_iter = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [3:0] c_op_add  = 4'h0;
    localparam logic [3:0] c_op_sub  = 4'h1;
    localparam logic [3:0] c_op_and  = 4'h2;
    localparam logic [3:0] c_op_or   = 4'h3;
    localparam logic [3:0] c_op_xor  = 4'h4;
    localparam logic [3:0] c_op_sll  = 4'h5;
    localparam logic [3:0] c_op_srl  = 4'h6;
    localparam logic [3:0] c_op_sra  = 4'h7;
    localparam logic [3:0] c_op_slt  = 4'h8;
    localparam logic [3:0] c_op_sltu = 4'h9;
    localparam logic [3:0] c_op_mul  = 4'hA;
    localparam logic [3:0] c_op_divu = 4'hB;
    localparam logic [3:0] c_op_remu = 4'hC;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [3:0]         r_ctrl;
    logic [D_WIDTH-1:0] r_a;
    logic [D_WIDTH-1:0] r_b;
    logic [D_WIDTH-1:0] r_acc;
    logic [D_WIDTH-1:0] r_aluout;
    logic               r_busy;
    logic               r_done;

    logic [D_WIDTH-1:0] w_op2;
    logic [SW-1:0]      w_shamt;
    logic [D_WIDTH-1:0] w_fast;
    logic               w_slow;
    logic [D_WIDTH-1:0] w_mul_acc;
    logic [D_WIDTH:0]   w_rem_sh;
    logic [D_WIDTH:0]   w_diff;
    logic               w_qbit;
    logic [D_WIDTH-1:0] w_rem_nxt;
    logic [D_WIDTH-1:0] w_quo_nxt;

    // Branch path: operand mux and equality stay combinational in every state.
    assign w_op2   = alusrc ? immop : regop2;
    assign aluop2  = w_op2;
    assign eq      = (aluop1 == w_op2);
    assign w_shamt = w_op2[SW-1:0];

    always_comb begin
        w_fast = '0;
        case (aluctrl)
            c_op_add:  w_fast = aluop1 + w_op2;
            c_op_sub:  w_fast = aluop1 - w_op2;
            c_op_and:  w_fast = aluop1 & w_op2;
            c_op_or:   w_fast = aluop1 | w_op2;
            c_op_xor:  w_fast = aluop1 ^ w_op2;
            c_op_sll:  w_fast = aluop1 << w_shamt;
            c_op_srl:  w_fast = aluop1 >> w_shamt;
            c_op_sra:  w_fast = $unsigned($signed(aluop1) >>> w_shamt);
            c_op_slt:  w_fast = {{(D_WIDTH-1){1'b0}}, ($signed(aluop1) < $signed(w_op2))};
            c_op_sltu: w_fast = {{(D_WIDTH-1){1'b0}}, (aluop1 < w_op2)};
            default:   w_fast = '0;
        endcase
    end

    generate
        if (MULDIV_EN != 0) begin : g_muldiv
            assign w_slow = (aluctrl == c_op_mul) || (aluctrl == c_op_divu) ||
                            (aluctrl == c_op_remu);
        end else begin : g_no_muldiv
            assign w_slow = 1'b0;
        end
    endgenerate

    // MUL: r_a is the left-shifting multiplicand, r_b the right-shifting multiplier.
    assign w_mul_acc = r_acc + (r_b[0] ? r_a : '0);

    // DIVU/REMU: r_acc is the partial remainder, r_b shifts dividend out MSB-first
    // while quotient bits shift in. A zero divisor naturally yields all-ones/dividend.
    assign w_rem_sh  = {r_acc, r_b[D_WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_a};
    assign w_qbit    = ~w_diff[D_WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[D_WIDTH-1:0] : w_rem_sh[D_WIDTH-1:0];
    assign w_quo_nxt = {r_b[D_WIDTH-2:0], w_qbit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_aluout <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_ctrl <= aluctrl;
                        if (w_slow) begin
                            r_state <= c_st_iter;
                            r_busy  <= 1'b1;
                            r_cnt   <= CW'(D_WIDTH);
                            r_acc   <= '0;
                            if (aluctrl == c_op_mul) begin
                                r_a <= aluop1;
                                r_b <= w_op2;
                            end else begin
                                r_a <= w_op2;
                                r_b <= aluop1;
                            end
                        end else begin
                            r_aluout <= w_fast;
                            r_state  <= c_st_done;
                            r_done   <= 1'b1;
                        end
                    end
                end
                c_st_iter: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_ctrl == c_op_mul) begin
                        r_acc <= w_mul_acc;
                        r_a   <= r_a << 1;
                        r_b   <= r_b >> 1;
                    end else begin
                        r_acc <= w_rem_nxt;
                        r_b   <= w_quo_nxt;
                    end
                    if (r_cnt == CW'(1)) begin
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        if (r_ctrl == c_op_mul) begin
                            r_aluout <= w_mul_acc;
                        end else if (r_ctrl == c_op_divu) begin
                            r_aluout <= w_quo_nxt;
                        end else begin
                            r_aluout <= w_rem_nxt;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign aluout = r_aluout;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
